fan_line_gen: RTL and testbench
===============================

# fan_line_gen

Stream-to-line packer that feeds `fan_adder` in the sparse tensor core. It accepts one sparse partial product per cycle, tagged with its output row, over a valid/ready stream. It groups the products into beats of NUM_IN slots and generates the per-slot control bits that tell the fan network where each same-row reduction segment starts and ends. It drives one registered `in` bus per beat to the adder array.

## Interface
- DW_DATA, 8: partial-product width
- DW_ROW, 5: row-index width
- DW_CTRL, 4: control width; must equal 4
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL: slot width
- NUM_IN, 6: slots per beat (≥2)
- clk  in  1: clock; all state on rising edge
- rst_n  in  1: reset; asynchronous, active-low
- in_valid  in  1: product available
- in_ready  out  1: product accepted when in_valid && in_ready
- in_data  in  DW_DATA: partial product
- in_row  in  DW_ROW: destination row
- in_last  in  1: final product of the tile
- out_valid  out  1: beat available
- out_ready  in  1: beat consumed when out_valid && out_ready
- out_line  out  NUM_IN*DW_LINE: beat; slot i at [i*DW_LINE +: DW_LINE], slot 0 oldest

## Operation
- Slot layout: {ctrl[3:0], row, data}.
  - ctrl[3] is valid.
  - ctrl[2] is seg_start.
  - ctrl[1] is seg_end.
  - ctrl[0] is tile_last.
- Invalid slots are all-zero.
- seg_start: set on the first product of a tile, or when the row differs from the previous product's row. The previous product may be in the prior beat, via a registered prev_row/prev_valid.
- seg_end: set when the product is in_last, or when the next product's row differs.
- Pack buffer: NUM_IN entries plus a count `cnt` (0..NUM_IN).
- FSM states: FILL, PEEK, FLUSH.
  - FILL: in_ready=1 if cnt<NUM_IN. Each accept writes data/row into entry cnt and computes its seg_start.
    - Each accept also finalizes the seg_end of entry cnt-1, using the new row.
    - If the accept has in_last=1, seg_end and tile_last are set on that entry and the state goes to FLUSH.
    - If the accept fills entry NUM_IN-1 without in_last, the state goes to PEEK.
  - PEEK: in_ready=0.
    - When in_valid=1, set seg_end of entry NUM_IN-1 iff in_row≠row[NUM_IN-1]. The product is not consumed; it stays on the bus and is accepted in the next FILL.
    - Then go to FLUSH.
  - FLUSH: when the output register is free (out_valid=0, or out_ready=1 this cycle):
    - load out_line from the buffer, padding slots ≥cnt with zero, and set out_valid=1;
    - clear cnt and go to FILL.
    - After a tile_last beat, prev_valid is cleared, so the next product starts a new segment.
- Output register holds out_line stable while out_valid && !out_ready.
- Rows are compared with an exact DW_ROW-bit equality. No arithmetic is performed on data.

## Timing
- Reset values:
  - out_valid=0, out_line=0, in_ready=0 during reset.
  - State=FILL, cnt=0, prev_valid=0.
  - in_ready rises the first cycle after rst_n deasserts.
- Full beat: the last slot is accepted in cycle t, PEEK resolves in cycle t+k (k≥1, waiting for in_valid), FLUSH runs in t+k+1, and out_valid is high from t+k+2.
- in_last beat: out_valid is high 2 cycles after the in_last accept (FLUSH, then register).
- Output backpressure: FLUSH stalls, in_ready stays 0, and no product is lost. The buffer is not overwritten until it has been transferred.
- Same-cycle out_ready and FLUSH load: the old beat is consumed and the new beat is loaded with no bubble.
- in_last with cnt reaching NUM_IN: go straight to FLUSH, skipping PEEK.
- Single-product tile: one beat, slot0 ctrl=4'b1111, all other slots zero.
- Reset mid-beat: the buffer and output are discarded and out_valid drops immediately (async).
- Throughput: NUM_IN products per NUM_IN+2 cycles when products arrive back-to-back and out_ready=1.

## Structure
- Shared package `fan_pkg` holds:
  - ctrl bit positions: CTRL_VALID=3, CTRL_START=2, CTRL_END=1, CTRL_LAST=0;
  - the DW_LINE derivation;
  - the slot-pack function.
- `fan_adder` must use the same constants.
- One sub-module, `fan_seg_flag`: purely combinational. From (prev_valid, prev_row, row, next_valid, next_row, last) it computes {start, end}.
- FSM, buffer and output register live in `fan_line_gen`.

## Test plan
All cases use defaults, NUM_IN=6.
- Rows 0,0,0,1,1,2, then row 3 with last. Beat0 ctrl is, slot0..5:
  - 1100, 1000, 1010, 1100, 1010, 1110.
  - Beat1 slot0=1111, slots1..5 zero.
- Rows 0×6 then row 0 with last, data 1..7. Beat0 slot5 ctrl is 1000: no seg_end, continued into the next beat. Beat1 slot0 ctrl is 1011: no start, end, last.
- Three products rows 2,2,4 with last. One beat:
  - ctrl 1100, 1010, 1111;
  - slots3..5 all-zero;
  - out_valid high 2 cycles after the third accept.
- Hold out_ready=0 for 10 cycles with a full beat pending and a second full beat complete. Required:
  - out_line is stable;
  - in_ready=0 once the buffer is full;
  - both beats are delivered intact once out_ready=1.
- Assert rst_n=0 mid-fill (cnt=3). Required:
  - out_valid=0 asynchronously;
  - after release, the next product gets seg_start=1 and lands in slot0.
- Back-to-back random rows, always-ready sink, 500 products. A scoreboard checks:
  - every product appears once, in order;
  - seg flags match a reference model;
  - throughput equals 6 products per 8 cycles.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared constants, FSM/debug types and slot packing for the fan network
// (fan_line_gen and fan_adder).
package fan_pkg;

  localparam int CTRL_W     = 4;
  localparam int CTRL_VALID = 3;
  localparam int CTRL_START = 2;
  localparam int CTRL_END   = 1;
  localparam int CTRL_LAST  = 0;

  // Packing is done at this fixed width and then truncated to the real slot width.
  localparam int PACK_W = 128;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PEEK  = 2'd1,
    ST_FLUSH = 2'd2
  } fan_state_e;

  typedef struct packed {
    fan_state_e state;
    logic       rdy_en;
    logic       prev_valid;
  } fan_dbg_t;

  function automatic int line_width(input int dw_data, input int dw_row, input int dw_ctrl);
    return dw_data + dw_row + dw_ctrl;
  endfunction

  // Slot layout is {ctrl, row, data} with data in the low bits.
  function automatic logic [PACK_W-1:0] pack_slot(
    input logic [CTRL_W-1:0] ctrl,
    input logic [63:0]       row,
    input logic [63:0]       data,
    input int                dw_row,
    input int                dw_data
  );
    logic [PACK_W-1:0] d;
    logic [PACK_W-1:0] r;
    logic [PACK_W-1:0] c;
    d = PACK_W'(data) & ((PACK_W'(1) << dw_data) - PACK_W'(1));
    r = (PACK_W'(row) & ((PACK_W'(1) << dw_row) - PACK_W'(1))) << dw_data;
    c = PACK_W'(ctrl) << (dw_row + dw_data);
    return c | r | d;
  endfunction

endpackage

// File: rtl/fan_seg_flag.sv
// Segment boundary flags for one product, from its neighbours in the stream.
module fan_seg_flag #(
  parameter int DW_ROW = 5
) (
  input  logic              prev_valid,
  input  logic [DW_ROW-1:0] prev_row,
  input  logic [DW_ROW-1:0] row,
  input  logic              next_valid,
  input  logic [DW_ROW-1:0] next_row,
  input  logic              last,
  output logic              seg_start,
  output logic              seg_end
);

  assign seg_start = !prev_valid || (prev_row != row);
  assign seg_end   = last || (next_valid && (next_row != row));

endmodule

// File: rtl/fan_line_gen.sv
// Packs a stream of row-tagged partial products into NUM_IN-slot beats with
// per-slot segment control bits for the fan adder array.
module fan_line_gen
  import fan_pkg::*;
#(
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 5,
  parameter int DW_CTRL = 4,
  parameter int DW_LINE = line_width(DW_DATA, DW_ROW, DW_CTRL),
  parameter int NUM_IN  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW_DATA-1:0]        in_data,
  input  logic [DW_ROW-1:0]         in_row,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_IN*DW_LINE-1:0] out_line
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds its payload stable until then, and ready never
  // depends combinationally on valid of the same port.

  localparam int CW = $clog2(NUM_IN + 1);

  fan_state_e state;
  fan_state_e state_nx;
  fan_dbg_t   dbg;

  logic [CW-1:0]     cnt;
  logic              rdy_en;
  logic              prev_valid;
  logic [DW_ROW-1:0] prev_row;

  logic [DW_DATA-1:0] buf_data [NUM_IN];
  logic [DW_ROW-1:0]  buf_row  [NUM_IN];
  logic [NUM_IN-1:0]  buf_start;
  logic [NUM_IN-1:0]  buf_end;
  logic [NUM_IN-1:0]  buf_last;

  logic accept;
  logic load;
  logic new_start;
  logic new_end;
  logic prev_end;
  logic unused_start;

  logic [DW_CTRL-1:0]        ctrl_v;
  logic [NUM_IN*DW_LINE-1:0] line_nx;

  assign dbg = '{state: state, rdy_en: rdy_en, prev_valid: prev_valid};

  // Flags for the incoming product (start, and end when it closes the tile).
  fan_seg_flag #(.DW_ROW(DW_ROW)) u_new_flag (
    .prev_valid (dbg.prev_valid),
    .prev_row   (prev_row),
    .row        (in_row),
    .next_valid (1'b0),
    .next_row   (in_row),
    .last       (in_last),
    .seg_start  (new_start),
    .seg_end    (new_end)
  );

  // End flag of the most recently stored product, now that its successor is visible.
  fan_seg_flag #(.DW_ROW(DW_ROW)) u_prev_flag (
    .prev_valid (1'b0),
    .prev_row   (prev_row),
    .row        (prev_row),
    .next_valid (in_valid),
    .next_row   (in_row),
    .last       (1'b0),
    .seg_start  (unused_start),
    .seg_end    (prev_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FILL: begin
        if (accept) begin
          if (in_last) begin
            state_nx = ST_FLUSH;
          end else if (cnt == CW'(NUM_IN - 1)) begin
            state_nx = ST_PEEK;
          end
        end
      end
      ST_PEEK:  if (in_valid) state_nx = ST_FLUSH;
      ST_FLUSH: if (load) state_nx = ST_FILL;
      default:  state_nx = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    case (dbg.state)
      ST_FILL:  in_ready = dbg.rdy_en && (cnt < CW'(NUM_IN));
      ST_FLUSH: load = !out_valid || out_ready;
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;

  // rdy_en keeps in_ready low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      cnt        <= '0;
      prev_valid <= 1'b0;
      prev_row   <= '0;
      buf_start  <= '0;
      buf_end    <= '0;
      buf_last   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (load) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        prev_row   <= in_row;
        prev_valid <= !in_last;
      end
      for (int i = 0; i < NUM_IN; i++) begin
        if (accept && cnt == CW'(i)) begin
          buf_start[i] <= new_start;
          buf_end[i]   <= new_end;
          buf_last[i]  <= in_last;
        end
        if (accept && cnt == CW'(i + 1)) begin
          buf_end[i] <= prev_end;
        end
      end
      if (state == ST_PEEK && in_valid) begin
        buf_end[NUM_IN-1] <= prev_end;
      end
    end
  end

  // Payload storage needs no reset: slots at or above cnt are never emitted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (accept && cnt == CW'(i)) begin
        buf_data[i] <= in_data;
        buf_row[i]  <= in_row;
      end
    end
  end

  always_comb begin
    line_nx = '0;
    ctrl_v  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ctrl_v             = '0;
      ctrl_v[CTRL_VALID] = 1'b1;
      ctrl_v[CTRL_START] = buf_start[i];
      ctrl_v[CTRL_END]   = buf_end[i];
      ctrl_v[CTRL_LAST]  = buf_last[i];
      if (CW'(i) < cnt) begin
        line_nx[i*DW_LINE +: DW_LINE] =
          DW_LINE'(pack_slot(ctrl_v, 64'(buf_row[i]), 64'(buf_data[i]), DW_ROW, DW_DATA));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_line  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_line  <= line_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fan_line_gen.sv
// Directed and randomized bench for fan_line_gen against a stream-level model.
module tb_fan_line_gen;

  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 5;
  localparam int DW_LINE = 17;
  localparam int NUM_IN  = 6;
  localparam int BOUND   = 200;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [DW_DATA-1:0]        in_data;
  logic [DW_ROW-1:0]         in_row;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_IN*DW_LINE-1:0] out_line;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic drv_done;

  logic [DW_ROW-1:0]  prod_row[$];
  logic [DW_DATA-1:0] prod_data[$];
  logic               prod_last[$];
  int                 acc_cyc[$];
  logic [DW_LINE-1:0] exp_q[$];
  logic [DW_LINE-1:0] obs_q[$];

  fan_line_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_row    (in_row),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_line  (out_line)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a beat is transferred at the edge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      for (int i = 0; i < NUM_IN; i++) obs_q.push_back(out_line[i*DW_LINE +: DW_LINE]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW_ROW-1:0] r, input logic [DW_DATA-1:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_row   = r;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      prod_row.push_back(r);
      prod_data.push_back(d);
      prod_last.push_back(l);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_sb();
    prod_row.delete();
    prod_data.delete();
    prod_last.delete();
    acc_cyc.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Flags come from the whole accepted stream: a segment starts at a tile start
  // or a row change and ends at tile end or before a row change; beats close
  // after NUM_IN products or at tile end, zero-padded.
  task automatic build_expected();
    int pos;
    int n;
    logic [3:0] c;
    logic first;
    exp_q.delete();
    pos = 0;
    n = prod_row.size();
    for (int k = 0; k < n; k++) begin
      first = (k == 0) ? 1'b1 : prod_last[k-1];
      c[3] = 1'b1;
      c[2] = first ? 1'b1 : (prod_row[k] != prod_row[k-1]);
      c[1] = prod_last[k] ? 1'b1 : ((k + 1 < n) ? (prod_row[k+1] != prod_row[k]) : 1'b0);
      c[0] = prod_last[k];
      exp_q.push_back({c, prod_row[k], prod_data[k]});
      pos++;
      if (prod_last[k] || pos == NUM_IN) begin
        while (pos < NUM_IN) begin
          exp_q.push_back('0);
          pos++;
        end
        pos = 0;
      end
    end
  endtask

  task automatic wait_drain(input int n);
    int w;
    w = 0;
    while (obs_q.size() < n && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_row = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_line !== '0) begin errors++; $display("FAIL reset_out_line: got %h want 0", out_line); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_segments();
    logic [4:0] rows [7];
    logic [3:0] ctrl0 [6];
    logic [DW_LINE-1:0] s;
    clear_sb();
    rows = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd3};
    ctrl0 = '{4'b1100, 4'b1000, 4'b1010, 4'b1100, 4'b1010, 4'b1110};
    for (int k = 0; k < 7; k++) send(rows[k], DW_DATA'($urandom_range(0, 255)), k == 6);
    idle();
    build_expected();
    wait_drain(exp_q.size());
    for (int i = 0; i < 6; i++) begin
      s = obs_q[i];
      checks++;
      if (s[16:13] !== ctrl0[i]) begin errors++; $display("FAIL seg_ctrl slot%0d: got %b want %b", i, s[16:13], ctrl0[i]); end
    end
    s = obs_q[6];
    checks++; if (s[16:13] !== 4'b1111) begin errors++; $display("FAIL seg_beat1_ctrl: got %b want 1111", s[16:13]); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL seg_count: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL seg_slot%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_continue();
    logic [DW_LINE-1:0] s;
    clear_sb();
    for (int k = 0; k < 7; k++) send(5'd0, DW_DATA'(k + 1), k == 6);
    idle();
    build_expected();
    wait_drain(exp_q.size());
    s = obs_q[5];
    checks++; if (s[16:13] !== 4'b1000) begin errors++; $display("FAIL cont_slot5_ctrl: got %b want 1000", s[16:13]); end
    s = obs_q[6];
    checks++; if (s[16:13] !== 4'b1011) begin errors++; $display("FAIL cont_beat1_ctrl: got %b want 1011", s[16:13]); end
    checks++; if (s[7:0] !== 8'd7) begin errors++; $display("FAIL cont_beat1_data: got %0d want 7", s[7:0]); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL cont_count: got %0d slots want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL cont_slot%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_short();
    clear_sb();
    send(5'd2, 8'h11, 1'b0);
    send(5'd2, 8'h22, 1'b0);
    send(5'd4, 8'h33, 1'b1);
    idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_lat1: out_valid=%0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL short_lat2: out_valid=%0b want 1", out_valid); end
    @(posedge clk);
    #1;
    build_expected();
    wait_drain(exp_q.size());
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL short_count: got %0d slots want 6", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_slot%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_IN*DW_LINE-1:0] snap;
    int w;
    clear_sb();
    out_ready = 1'b0;
    drv_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 13; k++)
          send(DW_ROW'($urandom_range(0, 3)), DW_DATA'($urandom_range(0, 255)), k == 12);
        idle();
        drv_done = 1'b1;
      end
    join_none
    repeat (25) @(negedge clk);
    snap = out_line;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (out_line !== snap) begin errors++; $display("FAIL bp_stable c%0d: got %h want %h", c, out_line, snap); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %0b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c%0d: got %0b want 1", c, out_valid); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: out_valid=%0b want 1", out_valid); end
    w = 0;
    while (!drv_done && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    checks++; if (drv_done !== 1'b1) begin errors++; $display("FAIL bp_driver_done: got %0b want 1", drv_done); end
    @(posedge clk);
    #1;
    build_expected();
    wait_drain(exp_q.size());
    checks++; if (obs_q.size() != 18) begin errors++; $display("FAIL bp_count: got %0d slots want 18", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_slot%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW_LINE-1:0] s;
    logic [DW_DATA-1:0] d;
    clear_sb();
    out_ready = 1'b0;
    send(5'd5, 8'h5a, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_held: out_valid=%0b want 1", out_valid); end
    @(posedge clk);
    #1;
    send(5'd1, 8'h01, 1'b0);
    send(5'd1, 8'h02, 1'b0);
    send(5'd2, 8'h03, 1'b0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %0b want 0", in_ready); end
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    d = DW_DATA'($urandom_range(0, 255));
    send(5'd9, d, 1'b1);
    idle();
    build_expected();
    wait_drain(exp_q.size());
    s = obs_q[0];
    checks++; if (s !== {4'b1111, 5'd9, d}) begin errors++; $display("FAIL rmid_slot0: got %h want %h", s, {4'b1111, 5'd9, d}); end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL rmid_count: got %0d slots want 6", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_slot%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int n_err;
    clear_sb();
    out_ready = 1'b1;
    for (int k = 0; k < 500; k++)
      send(DW_ROW'($urandom_range(0, 3)), DW_DATA'($urandom_range(0, 255)), k == 499);
    idle();
    build_expected();
    wait_drain(exp_q.size());
    checks++; if (obs_q.size() != 504) begin errors++; $display("FAIL rand_count: got %0d slots want 504", obs_q.size()); end
    n_err = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        n_err++;
        if (n_err < 10) $display("FAIL rand_slot%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (acc_cyc.size() != 500) begin
      errors++;
      $display("FAIL rand_accepts: got %0d want 500", acc_cyc.size());
    end else begin
      if (acc_cyc[492] - acc_cyc[0] != 82 * 8) begin
        errors++;
        $display("FAIL rand_throughput: got %0d cycles want %0d", acc_cyc[492] - acc_cyc[0], 82 * 8);
      end
      checks++;
      if (acc_cyc[497] - acc_cyc[0] != 82 * 8 + 5) begin
        errors++;
        $display("FAIL rand_throughput_tail: got %0d cycles want %0d", acc_cyc[497] - acc_cyc[0], 82 * 8 + 5);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    drv_done = 1'b0;
    test_reset();
    test_segments();
    test_continue();
    test_short();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
